// File: rtl/nvdla_dmaif_pkg.sv
// Shared constants and helpers for the DMA-interface read-response path.
// Contents:
//   DMAIF_PD_W - default response payload width (data plus mask bits)
//   ARB_RR     - round-robin arbitration mode
//   ARB_FIXED  - fixed-priority arbitration mode, lowest index wins
//   COLL_W     - collision counter width
//   COLL_SAT   - collision counter saturation value
//   SRC_W()    - width of a port-index field, max(1, clog2(n))
package nvdla_dmaif_pkg;

    localparam int unsigned DMAIF_PD_W = 514;

    localparam int unsigned ARB_RR    = 0;
    localparam int unsigned ARB_FIXED = 1;

    localparam int unsigned       COLL_W   = 16;
    localparam logic [COLL_W-1:0] COLL_SAT = '1;

    function automatic int unsigned SRC_W(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/nvdla_dmaif_rsp_fifo.sv
// Per-port read-response buffer: synchronous, non-fall-through FIFO with a
// registered occupancy count. A beat written at edge t is visible at the head
// after edge t.
// Ports:
//   clk_i    - core clock
//   rst_i    - asynchronous active-high reset
//   wr_en_i  - write strobe (caller guarantees !full_o)
//   wr_pd_i  - write payload
//   rd_pop_i - pop the head entry (ignored while empty)
//   rd_pd_o  - head payload
//   full_o   - buffer full, from the registered count
//   empty_o  - buffer empty, from the registered count
module nvdla_dmaif_rsp_fifo
    import nvdla_dmaif_pkg::*;
#(
    parameter int unsigned PD_W     = DMAIF_PD_W,
    parameter int unsigned IN_DEPTH = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            wr_en_i,
    input  logic [PD_W-1:0] wr_pd_i,
    input  logic            rd_pop_i,
    output logic [PD_W-1:0] rd_pd_o,
    output logic            full_o,
    output logic            empty_o
);

    localparam int unsigned PTR_W = $clog2(IN_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IN_DEPTH);

    logic [PD_W-1:0]  mem_q [IN_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pop_en;

    assign full_o  = (cnt_q == FULL_CNT);
    assign empty_o = (cnt_q == '0);
    assign pop_en  = rd_pop_i && !empty_o;
    assign rd_pd_o = mem_q[rd_ptr_q];

    // Pointers are PTR_W bits wide, so IN_DEPTH being a power of two makes
    // the natural overflow the modulo wrap.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q + CNT_W'(wr_en_i) - CNT_W'(pop_en);
        if (wr_en_i) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop_en) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_ptr_q] <= wr_pd_i;
        end
    end

endmodule

// File: rtl/nvdla_dmaif_rdrsp_arb.sv
// DMA-interface read-response arbiter: buffers read-response beats from
// NUM_IF memory-interface ports, picks one beat per cycle (round-robin or
// fixed priority) and presents it through a registered output stage.
// Ports:
//   nvdla_core_clk    - core clock
//   nvdla_core_rst    - asynchronous active-high reset
//   if_rd_rsp_pd      - per-port payload, port i at [i*PD_W +: PD_W]
//   if_rd_rsp_valid   - per-port valid
//   if_rd_rsp_ready   - per-port ready (buffer not full, 0 during reset)
//   dmaif_rd_rsp_pd   - merged payload
//   dmaif_rd_rsp_pvld - merged valid
//   dmaif_rd_rsp_prdy - consumer ready
//   dmaif_rd_rsp_src  - port index of the current output beat
//   collision_cnt     - saturating count of cycles with >1 requesting port
module nvdla_dmaif_rdrsp_arb
    import nvdla_dmaif_pkg::*;
#(
    parameter int unsigned NUM_IF   = 2,
    parameter int unsigned PD_W     = DMAIF_PD_W,
    parameter int unsigned IN_DEPTH = 2,
    parameter int unsigned ARB_MODE = ARB_RR
) (
    input  logic                         nvdla_core_clk,
    input  logic                         nvdla_core_rst,
    input  logic [NUM_IF*PD_W-1:0]       if_rd_rsp_pd,
    input  logic [NUM_IF-1:0]            if_rd_rsp_valid,
    output logic [NUM_IF-1:0]            if_rd_rsp_ready,
    output logic [PD_W-1:0]              dmaif_rd_rsp_pd,
    output logic                         dmaif_rd_rsp_pvld,
    input  logic                         dmaif_rd_rsp_prdy,
    output logic [SRC_W(NUM_IF)-1:0]     dmaif_rd_rsp_src,
    output logic [COLL_W-1:0]            collision_cnt
);

    localparam int unsigned SW = SRC_W(NUM_IF);

    logic [NUM_IF-1:0] empty;
    logic [NUM_IF-1:0] full;
    logic [NUM_IF-1:0] wr_en;
    logic [NUM_IF-1:0] pop;
    logic [PD_W-1:0]   head_pd [NUM_IF];

    logic              can_load;
    logic              grant_any;
    logic              grant;
    logic              multi_req;
    logic [SW-1:0]     grant_idx;

    logic              pvld_q, pvld_d;
    logic [PD_W-1:0]   pd_q, pd_d;
    logic [SW-1:0]     src_q, src_d;
    logic [SW-1:0]     last_q, last_d;
    logic [COLL_W-1:0] coll_q, coll_d;

    assign if_rd_rsp_ready = ~full & {NUM_IF{~nvdla_core_rst}};
    assign wr_en           = if_rd_rsp_valid & if_rd_rsp_ready;

    for (genvar g = 0; g < NUM_IF; g++) begin : g_port
        nvdla_dmaif_rsp_fifo #(
            .PD_W     (PD_W),
            .IN_DEPTH (IN_DEPTH)
        ) u_fifo (
            .clk_i    (nvdla_core_clk),
            .rst_i    (nvdla_core_rst),
            .wr_en_i  (wr_en[g]),
            .wr_pd_i  (if_rd_rsp_pd[g*PD_W +: PD_W]),
            .rd_pop_i (pop[g]),
            .rd_pd_o  (head_pd[g]),
            .full_o   (full[g]),
            .empty_o  (empty[g])
        );
    end

    assign can_load = !pvld_q || dmaif_rd_rsp_prdy;

    // Requester selection. Loops run from lowest to highest priority so the
    // last match wins.
    always_comb begin
        int unsigned idx;
        logic        seen;
        grant_any = 1'b0;
        grant_idx = '0;
        multi_req = 1'b0;
        seen      = 1'b0;
        idx       = 0;
        if (ARB_MODE == ARB_FIXED) begin
            for (int i = NUM_IF - 1; i >= 0; i--) begin
                if (!empty[i]) begin
                    grant_any = 1'b1;
                    grant_idx = SW'(i);
                end
            end
        end else begin
            // Offset NUM_IF is the last granted port itself: lowest priority.
            for (int unsigned off = NUM_IF; off >= 1; off--) begin
                idx = (32'(last_q) + off) % NUM_IF;
                if (!empty[idx]) begin
                    grant_any = 1'b1;
                    grant_idx = SW'(idx);
                end
            end
        end
        for (int i = 0; i < NUM_IF; i++) begin
            if (!empty[i]) begin
                if (seen) begin
                    multi_req = 1'b1;
                end
                seen = 1'b1;
            end
        end
    end

    always_comb begin
        grant  = can_load && grant_any;
        pop    = '0;
        pvld_d = pvld_q;
        pd_d   = pd_q;
        src_d  = src_q;
        last_d = last_q;
        coll_d = coll_q;
        for (int i = 0; i < NUM_IF; i++) begin
            pop[i] = grant && (grant_idx == SW'(i));
        end
        if (grant) begin
            pvld_d = 1'b1;
            pd_d   = head_pd[grant_idx];
            src_d  = grant_idx;
            last_d = grant_idx;
        end else if (dmaif_rd_rsp_prdy) begin
            pvld_d = 1'b0;
        end
        if (can_load && multi_req && (coll_q != COLL_SAT)) begin
            coll_d = coll_q + COLL_W'(1);
        end
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            pvld_q <= 1'b0;
            pd_q   <= '0;
            src_q  <= '0;
            last_q <= SW'(NUM_IF - 1);
            coll_q <= '0;
        end else begin
            pvld_q <= pvld_d;
            pd_q   <= pd_d;
            src_q  <= src_d;
            last_q <= last_d;
            coll_q <= coll_d;
        end
    end

    assign dmaif_rd_rsp_pvld = pvld_q;
    assign dmaif_rd_rsp_pd   = pd_q;
    assign dmaif_rd_rsp_src  = src_q;
    assign collision_cnt     = coll_q;

endmodule

// File: tb/tb_nvdla_dmaif_rdrsp_arb.sv
// Bench for nvdla_dmaif_rdrsp_arb: a 2-port round-robin instance and a 3-port
// fixed-priority instance, both checked every cycle against a queue-based
// reference model, plus a vector table and directed corner-case sequences.
module tb_nvdla_dmaif_rdrsp_arb;

    localparam int unsigned PW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2*PW-1:0] rr_pd  = '0;
    logic [1:0]      rr_vld = '0;
    logic [1:0]      rr_rdy;
    logic [PW-1:0]   rr_opd;
    logic            rr_pvld;
    logic            rr_prdy = 1'b0;
    logic [0:0]      rr_src;
    logic [15:0]     rr_coll;

    logic [3*PW-1:0] fx_pd  = '0;
    logic [2:0]      fx_vld = '0;
    logic [2:0]      fx_rdy;
    logic [PW-1:0]   fx_opd;
    logic            fx_pvld;
    logic            fx_prdy = 1'b0;
    logic [1:0]      fx_src;
    logic [15:0]     fx_coll;

    nvdla_dmaif_rdrsp_arb #(
        .NUM_IF   (2),
        .PD_W     (PW),
        .IN_DEPTH (2),
        .ARB_MODE (0)
    ) u_rr (
        .nvdla_core_clk    (clk),
        .nvdla_core_rst    (rst),
        .if_rd_rsp_pd      (rr_pd),
        .if_rd_rsp_valid   (rr_vld),
        .if_rd_rsp_ready   (rr_rdy),
        .dmaif_rd_rsp_pd   (rr_opd),
        .dmaif_rd_rsp_pvld (rr_pvld),
        .dmaif_rd_rsp_prdy (rr_prdy),
        .dmaif_rd_rsp_src  (rr_src),
        .collision_cnt     (rr_coll)
    );

    nvdla_dmaif_rdrsp_arb #(
        .NUM_IF   (3),
        .PD_W     (PW),
        .IN_DEPTH (2),
        .ARB_MODE (1)
    ) u_fx (
        .nvdla_core_clk    (clk),
        .nvdla_core_rst    (rst),
        .if_rd_rsp_pd      (fx_pd),
        .if_rd_rsp_valid   (fx_vld),
        .if_rd_rsp_ready   (fx_rdy),
        .dmaif_rd_rsp_pd   (fx_opd),
        .dmaif_rd_rsp_pvld (fx_pvld),
        .dmaif_rd_rsp_prdy (fx_prdy),
        .dmaif_rd_rsp_src  (fx_src),
        .collision_cnt     (fx_coll)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    // ---------------- reference model (k=0: round-robin, k=1: fixed) ----------
    logic [PW-1:0] mq [2][3][$];
    bit            m_pvld [2];
    logic [PW-1:0] m_pd   [2];
    int            m_src  [2];
    int            m_last [2];
    int            m_coll [2];

    function automatic int nports(input int k);
        return (k == 0) ? 2 : 3;
    endfunction
    function automatic logic in_vld(input int k, input int i);
        if (k == 0) return rr_vld[i];
        return fx_vld[i];
    endfunction
    function automatic logic [PW-1:0] in_pd(input int k, input int i);
        if (k == 0) return rr_pd[i*PW +: PW];
        return fx_pd[i*PW +: PW];
    endfunction
    function automatic logic in_prdy(input int k);
        return (k == 0) ? rr_prdy : fx_prdy;
    endfunction
    function automatic logic [63:0] out_pvld(input int k);
        return (k == 0) ? 64'(rr_pvld) : 64'(fx_pvld);
    endfunction
    function automatic logic [63:0] out_pd(input int k);
        return (k == 0) ? 64'(rr_opd) : 64'(fx_opd);
    endfunction
    function automatic logic [63:0] out_src(input int k);
        return (k == 0) ? 64'(rr_src) : 64'(fx_src);
    endfunction
    function automatic logic [63:0] out_coll(input int k);
        return (k == 0) ? 64'(rr_coll) : 64'(fx_coll);
    endfunction
    function automatic logic [63:0] out_rdy(input int k);
        return (k == 0) ? 64'(rr_rdy) : 64'(fx_rdy);
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 3; i++) mq[k][i].delete();
            m_pvld[k] = 0;
            m_pd[k]   = '0;
            m_src[k]  = 0;
            m_last[k] = nports(k) - 1;
            m_coll[k] = 0;
        end
    endtask

    // One clock edge of behaviour, from the inputs present at the edge.
    task automatic model_step();
        if (rst) return;
        for (int k = 0; k < 2; k++) begin
            int n;
            int nreq;
            int p;
            bit can;
            bit rdy [3];
            n    = nports(k);
            nreq = 0;
            p    = -1;
            for (int i = 0; i < n; i++) begin
                rdy[i] = (mq[k][i].size() < 2);
                if (mq[k][i].size() > 0) nreq++;
            end
            can = !m_pvld[k] || in_prdy(k);
            if (can && nreq >= 2 && m_coll[k] < 65535) m_coll[k]++;
            if (can && nreq > 0) begin
                if (k == 1) begin
                    for (int i = 0; i < n; i++)
                        if (p < 0 && mq[k][i].size() > 0) p = i;
                end else begin
                    for (int off = 1; off <= n; off++)
                        if (p < 0 && mq[k][(m_last[k] + off) % n].size() > 0)
                            p = (m_last[k] + off) % n;
                    m_last[k] = p;
                end
                m_pd[k]   = mq[k][p].pop_front();
                m_src[k]  = p;
                m_pvld[k] = 1;
            end else if (in_prdy(k)) begin
                m_pvld[k] = 0;
            end
            for (int i = 0; i < n; i++)
                if (in_vld(k, i) && rdy[i]) mq[k][i].push_back(in_pd(k, i));
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            logic [63:0] exp_rdy;
            exp_rdy = '0;
            for (int i = 0; i < nports(k); i++)
                exp_rdy[i] = !rst && (mq[k][i].size() < 2);
            check($sformatf("pvld%0d", k), out_pvld(k), 64'(m_pvld[k]));
            if (m_pvld[k]) begin
                check($sformatf("pd%0d", k), out_pd(k), 64'(m_pd[k]));
                check($sformatf("src%0d", k), out_src(k), 64'(m_src[k]));
            end
            check($sformatf("coll%0d", k), out_coll(k), 64'(m_coll[k]));
            check($sformatf("rdy%0d", k), out_rdy(k), exp_rdy);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        rr_vld  = '0;
        fx_vld  = '0;
        rr_prdy = 1'b0;
        fx_prdy = 1'b0;
        rst     = 1'b1;
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        compare_all();
        check("rst_rr_pd", 64'(rr_opd), 64'h0);
        check("rst_rr_src", 64'(rr_src), 64'h0);
        check("rst_fx_pd", 64'(fx_opd), 64'h0);
        check("rst_fx_src", 64'(fx_src), 64'h0);
        rst = 1'b0;
        #1;
        compare_all();
    endtask

    // Output payload/src must hold while the consumer stalls a valid beat.
    logic          st_v   = 1'b0;
    logic [PW-1:0] st_pd  = '0;
    logic [0:0]    st_src = '0;
    always @(posedge clk) begin
        st_v   <= rr_pvld && !rr_prdy && !rst;
        st_pd  <= rr_opd;
        st_src <= rr_src;
    end
    always @(negedge clk) begin
        if (st_v && !rst) begin
            check("stable_pd", 64'(rr_opd), 64'(st_pd));
            check("stable_src", 64'(rr_src), 64'(st_src));
        end
    end

    typedef struct {
        logic [1:0]    vld;
        logic [PW-1:0] pd1;
        logic          prdy;
        logic          e_pvld;
        logic [PW-1:0] e_pd;
        logic          e_src;
        logic [1:0]    e_rdy;
    } vec_t;
    vec_t tbl [12];

    int            rem [2];
    int            seq [2];
    int            got_src [$];
    logic [PW-1:0] got_pd [$];
    int            first_c;
    int            last_c;
    logic [2:0]    acc;

    initial begin
        model_reset();
        // Single beat on port 1: outputs sampled after each row's clock edge.
        for (int i = 0; i < 12; i++) tbl[i] = '{2'b00, '0, 1'b1, 1'b0, '0, 1'b0, 2'b11};
        tbl[5]  = '{2'b10, 32'h1A5, 1'b1, 1'b0, '0, 1'b0, 2'b11};
        tbl[6]  = '{2'b00, '0, 1'b1, 1'b1, 32'h1A5, 1'b1, 2'b11};
        tbl[8]  = '{2'b10, 32'h2B6, 1'b0, 1'b0, '0, 1'b0, 2'b11};
        tbl[9]  = '{2'b00, '0, 1'b0, 1'b1, 32'h2B6, 1'b1, 2'b11};
        tbl[10] = '{2'b00, '0, 1'b0, 1'b1, 32'h2B6, 1'b1, 2'b11};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            rr_vld  = tbl[i].vld;
            rr_pd   = {tbl[i].pd1, 32'h0};
            rr_prdy = tbl[i].prdy;
            tick();
            check($sformatf("tbl%0d_pvld", i), 64'(rr_pvld), 64'(tbl[i].e_pvld));
            if (tbl[i].e_pvld) begin
                check($sformatf("tbl%0d_pd", i), 64'(rr_opd), 64'(tbl[i].e_pd));
                check($sformatf("tbl%0d_src", i), 64'(rr_src), 64'(tbl[i].e_src));
            end
            check($sformatf("tbl%0d_rdy", i), 64'(rr_rdy), 64'(tbl[i].e_rdy));
            check($sformatf("tbl%0d_coll", i), 64'(rr_coll), 64'h0);
        end

        // Round-robin: both ports push 4 beats from the same cycle.
        do_reset();
        rem     = '{4, 4};
        seq     = '{0, 0};
        first_c = -1;
        last_c  = -1;
        got_src.delete();
        got_pd.delete();
        for (int c = 0; c < 20; c++) begin
            rr_prdy = 1'b1;
            for (int i = 0; i < 2; i++) begin
                rr_vld[i]          = (rem[i] > 0);
                rr_pd[i*PW +: PW]  = PW'(i * 256 + seq[i]);
            end
            acc = {1'b0, rr_vld & rr_rdy};
            tick();
            for (int i = 0; i < 2; i++) if (acc[i]) begin rem[i]--; seq[i]++; end
            if (rr_pvld) begin
                got_src.push_back(int'(rr_src));
                got_pd.push_back(rr_opd);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
        end
        check("rr_beats", 64'(got_src.size()), 64'd8);
        check("rr_no_bubble", 64'(last_c - first_c + 1), 64'd8);
        for (int j = 0; j < got_src.size() && j < 8; j++) begin
            check($sformatf("rr_src%0d", j), 64'(got_src[j]), 64'(j % 2));
            check($sformatf("rr_pd%0d", j), 64'(got_pd[j]), 64'((j % 2) * 256 + j / 2));
        end
        check("rr_coll_end", 64'(rr_coll), 64'd7);

        // Fixed priority, all three ports streaming.
        do_reset();
        fx_prdy = 1'b1;
        for (int c = 0; c < 12; c++) begin
            fx_vld = 3'b111;
            for (int i = 0; i < 3; i++) fx_pd[i*PW +: PW] = PW'(i * 256 + c);
            tick();
            if (fx_pvld) check($sformatf("fx_src_c%0d", c), 64'(fx_src), 64'h0);
        end
        check("fx_rdy_hi", 64'(fx_rdy[2:1]), 64'h0);
        check("fx_rdy0", 64'(fx_rdy[0]), 64'h1);

        // Consumer stall with port 0 streaming, then drain.
        do_reset();
        seq[0] = 0;
        for (int c = 0; c < 10; c++) begin
            rr_vld         = 2'b01;
            rr_pd[PW-1:0]  = PW'(32'hC000 + seq[0]);
            acc            = {2'b00, rr_rdy[0]};
            tick();
            if (acc[0]) seq[0]++;
        end
        check("hold_rdy0", 64'(rr_rdy[0]), 64'h0);
        check("hold_accepted", 64'(seq[0]), 64'd3);
        rr_vld  = 2'b00;
        rr_prdy = 1'b1;
        got_pd.delete();
        for (int c = 0; c < 6; c++) begin
            if (rr_pvld && rr_prdy) got_pd.push_back(rr_opd);
            tick();
        end
        check("drain_cnt", 64'(got_pd.size()), 64'd3);
        for (int j = 0; j < got_pd.size() && j < 3; j++)
            check($sformatf("drain_pd%0d", j), 64'(got_pd[j]), 64'(32'hC000 + j));

        // Random traffic on both instances.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            rr_vld  = 2'($urandom);
            rr_pd   = {$urandom, $urandom};
            rr_prdy = ($urandom_range(0, 3) != 0);
            fx_vld  = 3'($urandom);
            fx_pd   = {$urandom, $urandom, $urandom};
            fx_prdy = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Reset while three beats are in flight.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            rr_vld = 2'b11;
            rr_pd  = {$urandom, $urandom};
            tick();
        end
        rr_vld = 2'b00;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("mid_rst_pvld", 64'(rr_pvld), 64'h0);
        check("mid_rst_pd", 64'(rr_opd), 64'h0);
        check("mid_rst_src", 64'(rr_src), 64'h0);
        check("mid_rst_rdy", 64'(rr_rdy), 64'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("mid_rst_rdy_held", 64'(rr_rdy), 64'h0);
        rst = 1'b0;
        #1;
        check("post_rst_rdy", 64'(rr_rdy), 64'h3);
        rr_prdy            = 1'b1;
        rr_vld             = 2'b10;
        rr_pd[2*PW-1:PW]   = 32'h5A5A;
        tick();
        rr_vld = 2'b00;
        check("post_rst_lat1", 64'(rr_pvld), 64'h0);
        tick();
        check("post_rst_pvld", 64'(rr_pvld), 64'h1);
        check("post_rst_pd", 64'(rr_opd), 64'h5A5A);
        check("post_rst_src", 64'(rr_src), 64'h1);

        // Collision counter saturation.
        do_reset();
        rr_prdy = 1'b1;
        rr_vld  = 2'b11;
        repeat (70000) @(posedge clk);
        #1;
        check("coll_sat", 64'(rr_coll), 64'hFFFF);
        repeat (20) @(posedge clk);
        #1;
        check("coll_sat_hold", 64'(rr_coll), 64'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
